// File: rtl/seq_checker.sv
// Memory-game input judge: latches the stage pattern on start, then scores
// rising button edges against it with an inactivity timeout.
module seq_checker #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stage1,
  input  logic       stage2,
  input  logic       stage3,
  input  logic [1:0] data1,
  input  logic [1:0] data2,
  input  logic [1:0] data3,
  input  logic [3:0] btn,
  output logic [1:0] idx,
  output logic       hit,
  output logic       stage_clear,
  output logic       fail,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  state_t          state_r, state_s;
  logic [1:0]      idx_r, idx_s;
  logic [15:0]     timer_r, timer_s;
  logic [2:0][1:0] pat_r, pat_s;
  logic [1:0]      len_r, len_s;
  logic [3:0]      btn_q_r;
  logic            hit_r, hit_s;
  logic            stage_clear_r, fail_r, busy_r;

  logic [3:0] press_s;
  logic       event_s, onehot_s, match_s, last_s, start_ok_s;
  logic [1:0] code_s, exp_code_s, new_len_s;

  assign press_s    = btn & ~btn_q_r;
  assign event_s    = (press_s != 4'b0000);
  assign start_ok_s = start & (stage1 | stage2 | stage3);
  assign new_len_s  = stage3 ? 2'd3 : (stage2 ? 2'd2 : 2'd1);
  assign last_s     = (idx_r == (len_r - 2'd1));
  assign match_s    = onehot_s & (code_s == exp_code_s);

  // Decode the press vector into a symbol code; anything not one-hot is a miss
  always_comb begin
    onehot_s = 1'b1;
    code_s   = 2'd0;
    case (press_s)
      4'b0001: code_s = 2'd0;
      4'b0010: code_s = 2'd1;
      4'b0100: code_s = 2'd2;
      4'b1000: code_s = 2'd3;
      default: onehot_s = 1'b0;
    endcase
  end

  // Select the symbol expected at the current position
  always_comb begin
    exp_code_s = pat_r[0];
    case (idx_r)
      2'd0:    exp_code_s = pat_r[0];
      2'd1:    exp_code_s = pat_r[1];
      2'd2:    exp_code_s = pat_r[2];
      default: exp_code_s = pat_r[0];
    endcase
  end

  // Next-state logic; an accepted start overrides any press in the same cycle
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    timer_s = timer_r;
    pat_s   = pat_r;
    len_s   = len_r;
    hit_s   = 1'b0;
    if (start_ok_s) begin
      pat_s   = {data3, data2, data1};
      len_s   = new_len_s;
      idx_s   = 2'd0;
      timer_s = 16'd0;
      state_s = PLAY;
    end else begin
      case (state_r)
        PLAY: begin
          if (event_s) begin
            if (match_s) begin
              hit_s = 1'b1;
              if (last_s) begin
                state_s = PASS;
              end else begin
                idx_s   = idx_r + 2'd1;
                timer_s = 16'd0;
              end
            end else begin
              state_s = FAIL;
            end
          end else if (timer_r == TMAX) begin
            state_s = FAIL;
          end else begin
            timer_s = timer_r + 16'd1;
          end
        end
        default: state_s = state_r;
      endcase
    end
  end

  // State and registered outputs; btn_q resets high so held buttons need a re-press
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      idx_r         <= 2'd0;
      timer_r       <= 16'd0;
      pat_r         <= '0;
      len_r         <= 2'd0;
      btn_q_r       <= 4'b1111;
      hit_r         <= 1'b0;
      stage_clear_r <= 1'b0;
      fail_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      timer_r       <= timer_s;
      pat_r         <= pat_s;
      len_r         <= len_s;
      btn_q_r       <= btn;
      hit_r         <= hit_s;
      stage_clear_r <= (state_s == PASS);
      fail_r        <= (state_s == FAIL);
      busy_r        <= (state_s == PLAY);
    end
  end

  assign idx         = idx_r;
  assign hit         = hit_r;
  assign stage_clear = stage_clear_r;
  assign fail        = fail_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: directed test-plan steps followed by
// randomized play, all judged against a round-level reference model.
module tb_seq_checker;

  localparam int TO = 8;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PASS = 2, M_FAIL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stage1 = 1'b0, stage2 = 1'b0, stage3 = 1'b0;
  logic [1:0] data1 = 2'd0, data2 = 2'd0, data3 = 2'd0;
  logic [3:0] btn = 4'd0;
  logic [1:0] idx;
  logic       hit, stage_clear, fail, busy;

  int n_vec = 0;
  int n_err = 0;

  // reference model: the round as a list of symbols plus a quiet-cycle count
  int         m_mode = M_IDLE;
  int         m_pat[3];
  int         m_len = 0, m_pos = 0, m_quiet = 0;
  logic [3:0] m_btnq = 4'hF;
  logic       m_hit = 1'b0;

  seq_checker #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .stage1(stage1), .stage2(stage2), .stage3(stage3),
    .data1(data1), .data2(data2), .data3(data3),
    .btn(btn), .idx(idx), .hit(hit), .stage_clear(stage_clear),
    .fail(fail), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] press;
    press  = btn & ~m_btnq;
    m_btnq = rst ? 4'hF : btn;
    m_hit  = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_pos = 0; m_quiet = 0;
    end else if (start && (stage1 || stage2 || stage3)) begin
      m_pat[0] = data1; m_pat[1] = data2; m_pat[2] = data3;
      m_len = stage3 ? 3 : (stage2 ? 2 : 1);
      m_pos = 0; m_quiet = 0; m_mode = M_PLAY;
    end else if (m_mode == M_PLAY) begin
      if (press != 4'd0) begin
        if ($countones(press) == 1 && press[m_pat[m_pos]]) begin
          m_hit = 1'b1;
          if (m_pos == m_len - 1) m_mode = M_PASS;
          else begin m_pos++; m_quiet = 0; end
        end else m_mode = M_FAIL;
      end else begin
        m_quiet++;
        if (m_quiet == TO) m_mode = M_FAIL;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("idx",   {2'b00, idx},         4'(m_pos));
    chk("hit",   {3'b000, hit},        {3'b000, m_hit});
    chk("clear", {3'b000, stage_clear}, {3'b000, m_mode == M_PASS});
    chk("fail",  {3'b000, fail},       {3'b000, m_mode == M_FAIL});
    chk("busy",  {3'b000, busy},       {3'b000, m_mode == M_PLAY});
    start = 1'b0;
  endtask

  task automatic set_stage(input logic s1, input logic s2, input logic s3,
                           input logic [1:0] d1, input logic [1:0] d2, input logic [1:0] d3);
    stage1 = s1; stage2 = s2; stage3 = s3;
    data1 = d1; data2 = d2; data3 = d3;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    tick();
    btn = 4'd0;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset
    tick();
    rst = 1'b0;
    chk("rst_busy", {3'b000, busy}, 4'd0);
    chk("rst_idx", {2'b00, idx}, 4'd0);

    // pass at stage 3
    set_stage(1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd3);
    do_start();
    chk("s3_busy", {3'b000, busy}, 4'd1);
    idle(4); btn = 4'b0100; tick(); chk("s3_hit0", {3'b000, hit}, 4'd1); btn = 4'd0;
    idle(4); btn = 4'b0001; tick(); chk("s3_idx1", {2'b00, idx}, 4'd2); btn = 4'd0;
    idle(4); btn = 4'b1000; tick(); btn = 4'd0;
    chk("s3_clear", {3'b000, stage_clear}, 4'd1);
    chk("s3_busy0", {3'b000, busy}, 4'd0);
    idle(2);

    // wrong symbol
    set_stage(1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 2'd0);
    do_start();
    press(4'b0010);
    press(4'b0100);
    chk("wrong_fail", {3'b000, fail}, 4'd1);
    chk("wrong_idx", {2'b00, idx}, 4'd1);
    press(4'b0010);

    // multi-press
    set_stage(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    do_start();
    btn = 4'b0011; tick(); btn = 4'd0;
    chk("multi_fail", {3'b000, fail}, 4'd1);
    chk("multi_hit", {3'b000, hit}, 4'd0);
    tick();

    // all stage bits: three-symbol round
    set_stage(1'b1, 1'b1, 1'b1, 2'd1, 2'd2, 2'd3);
    do_start();
    press(4'b0010); press(4'b0100);
    chk("prio_busy", {3'b000, busy}, 4'd1);
    press(4'b1000);
    chk("prio_clear", {3'b000, stage_clear}, 4'd1);

    // timeout, then press exactly at the timeout edge
    set_stage(1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0);
    do_start();
    idle(TO - 1);
    chk("to_early", {3'b000, fail}, 4'd0);
    tick();
    chk("to_fail", {3'b000, fail}, 4'd1);
    do_start();
    idle(TO - 1);
    btn = 4'b0100; tick(); btn = 4'd0;
    chk("to_hit", {3'b000, hit}, 4'd1);
    chk("to_nofail", {3'b000, fail}, 4'd0);
    tick();

    // button held through reset and start
    btn = 4'b0100; rst = 1'b1; start = 1'b1; tick(); rst = 1'b0;
    do_start(); idle(3);
    chk("held_nohit", {3'b000, busy}, 4'd1);
    btn = 4'd0; tick(); btn = 4'b0100; tick();
    chk("held_repress", {3'b000, stage_clear}, 4'd1);
    btn = 4'd0; tick();

    // start with no stage bits keeps the state
    rst = 1'b1; tick(); rst = 1'b0;
    set_stage(1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd1);
    do_start();
    chk("nostage_idle", {3'b000, busy}, 4'd0);

    // restart during play latches the new pattern
    set_stage(1'b0, 1'b1, 1'b0, 2'd3, 2'd1, 2'd0);
    do_start(); press(4'b1000);
    set_stage(1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 2'd0);
    do_start();
    chk("restart_idx", {2'b00, idx}, 4'd0);
    press(4'b0001); press(4'b0100);
    chk("restart_clear", {3'b000, stage_clear}, 4'd1);

    // start and press together: press discarded, held button not recounted
    set_stage(1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0);
    btn = 4'b0010; do_start(); idle(2);
    chk("startwin_busy", {3'b000, busy}, 4'd1);
    btn = 4'd0; tick();

    // reset mid-round
    set_stage(1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd2);
    do_start(); press(4'b0001);
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0;
    chk("midrst_idx", {2'b00, idx}, 4'd0);
    chk("midrst_busy", {3'b000, busy}, 4'd0);

    // randomized play
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 11) == 0) begin
        start = 1'b1;
        {stage3, stage2, stage1} = 3'($urandom_range(0, 7));
        {data3, data2, data1} = 6'($urandom);
      end
      if (btn != 4'd0 && $urandom_range(0, 3) != 0) btn = 4'd0;
      else if ($urandom_range(0, 2) == 0) begin
        if (m_mode == M_PLAY && $urandom_range(0, 3) != 0) btn = 4'(1 << m_pat[m_pos]);
        else btn = 4'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
